alu_add_stage: RTL and testbench

//  Registered adder/flag stage directly downstream of the ALU operand extender.
//  - Consumes the extender's OPA, OPB and C carry-in and forms OPA+OPB+C.
//  - Registers the result behind a one-entry valid/ready output buffer.
//  - Holds the carry (borrow) and zero flags; the carry flag feeds back as the extender's cin.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_add_stage_adder_core.sv | 20 ++
 rtl/alu_add_stage.sv | 81 ++++++++
 tb/tb_alu_add_stage.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU add stage: op encoding, flag bundle and buffer state.
package alu_pkg;

   typedef enum logic [1:0] {
      ALU_ADD  = 2'b00,
      ALU_ADDC = 2'b01,
      ALU_SUB  = 2'b10,
      ALU_SUBC = 2'b11
   } alu_op_e;

   typedef struct packed {
      logic c;
      logic z;
   } alu_flags_t;

   typedef enum logic {
      ST_EMPTY,
      ST_FULL
   } add_state_e;

endpackage

// File: rtl/alu_add_stage_adder_core.sv
// Combinational WIDTH-bit adder with carry-in; carry-out kept as an extra bit.
module adder_core #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   logic [WIDTH:0] full;

   always_comb begin
      full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
      sum  = full[WIDTH-1:0];
      cout = full[WIDTH];
   end

endmodule

// File: rtl/alu_add_stage.sv
// Registered adder/flag stage: one-entry valid/ready output buffer plus C/Z flag registers.
module alu_add_stage
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] OPA,
   input  logic [WIDTH-1:0] OPB,
   input  logic             C,
   input  logic [1:0]       S,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             flag_we,
   output logic [WIDTH-1:0] result,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             cflag,
   output logic             zflag
);

   add_state_e       state, state_nxt;
   alu_flags_t       flags, new_flags;
   alu_op_e          op;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             accept;

   adder_core #(.WIDTH(WIDTH)) u_adder (
      .a    (OPA),
      .b    (OPB),
      .cin  (C),
      .sum  (sum),
      .cout (cout)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= ST_EMPTY;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_EMPTY: if (accept)               state_nxt = ST_FULL;
         ST_FULL:  if (out_ready && !accept) state_nxt = ST_EMPTY;
         default:                            state_nxt = ST_EMPTY;
      endcase
   end

   always_comb begin
      in_ready  = (state == ST_EMPTY) || out_ready;
      out_valid = (state == ST_FULL);
      accept    = in_valid && in_ready;
   end

   // Subtract ops report borrow, i.e. the inverted carry-out.
   always_comb begin
      op          = alu_op_e'(S);
      new_flags.z = (sum == '0);
      case (op)
         ALU_SUB, ALU_SUBC: new_flags.c = ~cout;
         default:           new_flags.c = cout;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         result <= '0;
         flags  <= '0;
      end else if (accept) begin
         result <= sum;
         if (flag_we) flags <= new_flags;
      end
   end

   assign cflag = flags.c;
   assign zflag = flags.z;

endmodule

// File: tb/tb_alu_add_stage.sv
// Scoreboard bench for alu_add_stage: expected results queued on acceptance, compared on consumption.
`timescale 1ns/1ps
module tb_alu_add_stage;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] OPA, OPB;
   logic       C;
   logic [1:0] S;
   logic       in_valid, in_ready, flag_we;
   logic [7:0] result;
   logic       out_valid, out_ready, cflag, zflag;

   typedef struct {
      logic [7:0] r;
      logic       c;
      logic       z;
   } exp_t;

   exp_t q[$];
   logic mc = 1'b0;
   logic mz = 1'b0;
   int   checks = 0;
   int   fails  = 0;

   always #5 clk = ~clk;

   alu_add_stage #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .OPA       (OPA),
      .OPB       (OPB),
      .C         (C),
      .S         (S),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .flag_we   (flag_we),
      .result    (result),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .cflag     (cflag),
      .zflag     (zflag)
   );

   // One clock: drive at negedge, score consumption/acceptance, return 1ns after posedge.
   task automatic cycle(input logic vld, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic [1:0] s, input logic we,
                        input logic ordy, input logic r);
      logic [8:0] full;
      exp_t       e;
      @(negedge clk);
      rst = r; in_valid = vld; OPA = a; OPB = b; C = c; S = s;
      flag_we = we; out_ready = ordy;
      #1;
      if (!r) begin
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               checks++; fails++;
               $display("FAIL sb_underflow: out_valid=1 with nothing expected, result=%h", result);
            end else begin
               e = q.pop_front();
               checks++;
               if (result !== e.r) begin
                  fails++;
                  $display("FAIL sb_result: got %h expected %h", result, e.r);
               end
               checks++;
               if (cflag !== e.c) begin
                  fails++;
                  $display("FAIL sb_cflag: got %b expected %b", cflag, e.c);
               end
               checks++;
               if (zflag !== e.z) begin
                  fails++;
                  $display("FAIL sb_zflag: got %b expected %b", zflag, e.z);
               end
            end
         end
         if (in_valid && in_ready) begin
            full = {1'b0, a} + {1'b0, b} + {8'h00, c};
            if (we) begin
               mc = s[1] ? ~full[8] : full[8];
               mz = (full[7:0] == 8'h00);
            end
            e.r = full[7:0]; e.c = mc; e.z = mz;
            q.push_back(e);
         end
      end
      @(posedge clk);
      if (r) begin
         q.delete();
         mc = 1'b0;
         mz = 1'b0;
      end
      #1;
   endtask

   task automatic drain();
      for (int unsigned i = 0; i < 10 && q.size() != 0; i++)
         cycle(1'b0, 8'h00, 8'h00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
      checks++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL drain_timeout: %0d results still pending, expected 0", q.size());
      end
   endtask

   task automatic test_reset();
      cycle(1'b1, 8'h12, 8'h34, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1);
      cycle(1'b0, 8'h00, 8'h00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
      checks++;
      if ({out_valid, result, cflag, zflag} !== 11'h000) begin
         fails++;
         $display("FAIL reset_state: got ov=%b res=%h c=%b z=%b expected 0/00/0/0",
                  out_valid, result, cflag, zflag);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_in_ready: got %b expected 1", in_ready);
      end
   endtask

   task automatic test_idle_ignored();
      for (int unsigned i = 0; i < 3; i++)
         cycle(1'b0, 8'($urandom), 8'($urandom), 1'b1, 2'b11, 1'b1, 1'b1, 1'b0);
      checks++;
      if ({out_valid, result, cflag, zflag} !== 11'h000) begin
         fails++;
         $display("FAIL idle_ignored: got ov=%b res=%h c=%b z=%b expected 0/00/0/0",
                  out_valid, result, cflag, zflag);
      end
   endtask

   task automatic test_add();
      cycle(1'b1, 8'h7F, 8'h01, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
      checks++;
      if ({out_valid, result, cflag, zflag} !== {1'b1, 8'h80, 1'b0, 1'b0}) begin
         fails++;
         $display("FAIL add_latency: got ov=%b res=%h c=%b z=%b expected 1/80/0/0",
                  out_valid, result, cflag, zflag);
      end
      cycle(1'b1, 8'hFF, 8'h01, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
      checks++;
      if ({result, cflag, zflag} !== {8'h00, 1'b1, 1'b1}) begin
         fails++;
         $display("FAIL add_wrap: got res=%h c=%b z=%b expected 00/1/1", result, cflag, zflag);
      end
      drain();
   endtask

   task automatic test_sub();
      cycle(1'b1, 8'h05, 8'hFA, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0);
      checks++;
      if ({result, cflag, zflag} !== {8'h00, 1'b0, 1'b1}) begin
         fails++;
         $display("FAIL sub_equal: got res=%h c=%b z=%b expected 00/0/1", result, cflag, zflag);
      end
      cycle(1'b1, 8'h00, 8'hFF, 1'b0, 2'b11, 1'b1, 1'b1, 1'b0);
      checks++;
      if ({result, cflag, zflag} !== {8'hFF, 1'b1, 1'b0}) begin
         fails++;
         $display("FAIL subc_borrow: got res=%h c=%b z=%b expected FF/1/0", result, cflag, zflag);
      end
      drain();
   endtask

   task automatic test_backpressure();
      cycle(1'b1, 8'h21, 8'h10, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
      for (int unsigned i = 0; i < 2; i++) begin
         cycle(1'b1, 8'h99, 8'h99, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
         checks++;
         if ({in_ready, out_valid, result} !== {1'b0, 1'b1, 8'h31}) begin
            fails++;
            $display("FAIL bp_hold: got ir=%b ov=%b res=%h expected 0/1/31",
                     in_ready, out_valid, result);
         end
      end
      cycle(1'b1, 8'h40, 8'h02, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0);
      checks++;
      if ({out_valid, result} !== {1'b1, 8'h43}) begin
         fails++;
         $display("FAIL bp_swap: got ov=%b res=%h expected 1/43", out_valid, result);
      end
      drain();
      checks++;
      if (out_valid !== 1'b0) begin
         fails++;
         $display("FAIL bp_empty: got out_valid=%b expected 0", out_valid);
      end
   endtask

   task automatic test_reset_mid_op();
      cycle(1'b1, 8'hFF, 8'h01, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
      checks++;
      if ({out_valid, result, cflag, zflag} !== 11'h000) begin
         fails++;
         $display("FAIL reset_mid_op: got ov=%b res=%h c=%b z=%b expected 0/00/0/0",
                  out_valid, result, cflag, zflag);
      end
      cycle(1'b1, 8'hFF, 8'h01, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
      checks++;
      if ({result, cflag, zflag} !== {8'h00, 1'b0, 1'b0}) begin
         fails++;
         $display("FAIL no_flag_we: got res=%h c=%b z=%b expected 00/0/0", result, cflag, zflag);
      end
      drain();
   endtask

   task automatic test_back_to_back();
      for (int unsigned i = 0; i < 40; i++)
         cycle(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 2'($urandom),
               1'($urandom), 1'b1, 1'b0);
      for (int unsigned i = 0; i < 80; i++)
         cycle(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 2'($urandom),
               1'($urandom), 1'($urandom), 1'b0);
      drain();
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; OPA = '0; OPB = '0; C = 1'b0; S = '0;
      flag_we = 1'b0; out_ready = 1'b1;
      test_reset();
      test_idle_ignored();
      test_add();
      test_sub();
      test_backpressure();
      test_reset_mid_op();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
